// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue.
//   PC_W / INSTR_W : widths of the program counter and instruction word
//   ENTRY_W        : width of one stored {pc, instr} pair
//   NOP            : instruction presented to decode when the queue is empty
//   fq_entry_t     : packed view of one stored pair
package fetch_queue_pkg;
    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int ENTRY_W = PC_W + INSTR_W;

    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;
endpackage

// File: rtl/fetch_queue_ram.sv
// fq_ram: DEPTH x ENTRY_W register array for the fetch queue.
// One synchronous write port, one asynchronous read port, so the head
// entry reaches decode without an extra register stage. Contents are
// deliberately not reset.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : {pc, instr} to store
//   raddr : read address (head pointer)
//   rdata : entry at raddr, combinational
module fq_ram
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [ENTRY_W-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [ENTRY_W-1:0]         rdata
);
    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] entry_vec [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [ENTRY_W-1:0] entry_reg;

        always_ff @(posedge clk) begin
            if (we && (waddr == AW'(gi))) begin
                entry_reg <= wdata;
            end
        end

        assign entry_vec[gi] = entry_reg;
    end

    assign rdata = entry_vec[raddr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: FIFO of {pc, instr} pairs between fetch and decode.
// Presents the oldest pair with a valid/ready handshake, throttles fetch
// through f_en, supports branch/jump flush (optionally keeping the oldest
// surviving entry as the delay slot) and counts flushed instructions.
//   clk, reset          : clock, asynchronous active-low reset
//   f_pc/f_instr/f_valid: pair offered by fetch
//   f_en                : fetch may advance (queue not full)
//   d_valid/d_pc/d_instr: head entry for decode (NOP when empty)
//   d_ready             : decode accepts the head this cycle
//   flush/flush_keep    : redirect; keep one survivor when flush_keep
//   count               : occupancy
//   flush_cnt           : saturating count of discarded entries
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [PC_W-1:0]          f_pc,
    input  logic [INSTR_W-1:0]       f_instr,
    input  logic                     f_valid,
    output logic                     f_en,
    output logic                     d_valid,
    output logic [PC_W-1:0]          d_pc,
    output logic [INSTR_W-1:0]       d_instr,
    input  logic                     d_ready,
    input  logic                     flush,
    input  logic                     flush_keep,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         flush_cnt
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int SUM_W = CNT_W + 1;

    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [CNT_W-1:0] flush_cnt_reg, flush_cnt_next;

    logic             push, pop;
    logic [CW-1:0]    survivors;
    logic [CW-1:0]    discarded;
    logic [SUM_W-1:0] fc_sum;
    logic [ENTRY_W-1:0] head_raw;
    fq_entry_t        head;

    fq_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_reg),
        .wdata ({f_pc, f_instr}),
        .raddr (rd_ptr_reg),
        .rdata (head_raw)
    );

    assign head    = head_raw;
    assign f_en    = (count_reg != CW'(DEPTH));
    assign d_valid = (count_reg != '0);
    assign d_pc    = d_valid ? head.pc    : '0;
    assign d_instr = d_valid ? head.instr : NOP;
    assign push    = f_valid & f_en;
    assign pop     = d_valid & d_ready;

    assign count     = count_reg;
    assign flush_cnt = flush_cnt_reg;

    // Entries still in order after this cycle's pop and push.
    assign survivors = count_reg - CW'(pop) + CW'(push);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        discarded   = '0;
        if (flush) begin
            if (flush_keep && (survivors != '0)) begin
                // The oldest survivor sits at rd_ptr+pop; when it is the
                // same-cycle push, wr_ptr already equals rd_ptr+pop, so it
                // is written exactly there.
                rd_ptr_next = rd_ptr_reg + AW'(pop);
                wr_ptr_next = rd_ptr_reg + AW'(pop) + AW'(1);
                count_next  = CW'(1);
                discarded   = survivors - CW'(1);
            end else begin
                // Push is written to RAM but wr_ptr does not advance, so
                // the slot is simply overwritten later.
                rd_ptr_next = wr_ptr_reg;
                count_next  = '0;
                discarded   = survivors;
            end
        end else begin
            wr_ptr_next = wr_ptr_reg + AW'(push);
            rd_ptr_next = rd_ptr_reg + AW'(pop);
            count_next  = survivors;
        end
    end

    assign fc_sum         = {1'b0, flush_cnt_reg} + SUM_W'(discarded);
    assign flush_cnt_next = fc_sum[CNT_W] ? '1 : fc_sum[CNT_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            flush_cnt_reg <= '0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            flush_cnt_reg <= flush_cnt_next;
        end
    end
endmodule
